// File: rtl/blk_67ac2c_if.sv
// Avalon-ST style sink bundle (data/valid/ready, readyLatency 0) feeding the line combiner.
interface blk_67ac2c_if #(
    parameter int DATA_WIDTH = 72
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/blk_67ac2c.sv
// Line combiner timing adapter: elastic FIFO turning a bursty XGMII sink into a gapless stream.
// Optional underflow statistics counter enabled by defining SONIC_LINE_COMBINER_STATS_EN.
module blk_67ac2c #(
    parameter int                    DATA_WIDTH  = 72,
    parameter int                    FIFO_DEPTH  = 8,
    parameter int                    ADDR_WIDTH  = 3,
    parameter int                    START_LEVEL = 4,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = 72'hFF_0707070707070707,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    blk_67ac2c_if.slave           sink,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_active,
    output logic                  underflow,
    output logic [CNT_WIDTH-1:0]  underflow_count
);
    typedef enum logic {PRIME, RUN} state_t;

    localparam logic [ADDR_WIDTH:0] FULL_LVL  = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] START_LVL = (ADDR_WIDTH+1)'(START_LEVEL);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   fill;
    logic                  push, pop, uf_nxt;

    // Ready comes only from registered fill so the source sees no in_valid->in_ready path.
    assign sink.ready = (fill != FULL_LVL);
    assign push       = sink.valid & sink.ready;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        uf_nxt    = 1'b0;
        case (state)
            PRIME: if (fill >= START_LVL) state_nxt = RUN;
            RUN: begin
                if (fill != '0) begin
                    pop = 1'b1;
                end else begin
                    uf_nxt    = 1'b1;
                    state_nxt = PRIME;
                end
            end
            default: state_nxt = PRIME;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PRIME;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            out_data   <= IDLE_WORD;
            out_active <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            underflow <= uf_nxt;
            if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({push, pop})
                2'b10:   fill <= fill + (ADDR_WIDTH+1)'(1);
                2'b01:   fill <= fill - (ADDR_WIDTH+1)'(1);
                default: fill <= fill;
            endcase
            out_data   <= pop ? mem[rd_ptr] : IDLE_WORD;
            out_active <= pop;
        end
    end

    // Storage has no reset; only entries below fill are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sink.data;
    end

`ifdef SONIC_LINE_COMBINER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            underflow_count <= '0;
        else if (uf_nxt && (underflow_count != '1))
            underflow_count <= underflow_count + CNT_WIDTH'(1);
    end
`else
    assign underflow_count = '0;
`endif

endmodule
